// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and flattened-port slicing helpers.
// Contents: default register-file geometry, the hardwired-zero register
// address, and the bit-offset helper used to slice flattened ra/rd buses.
package mips_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_ADDRW = 5;
  localparam int unsigned REG_ZERO  = 0;

  // LSB position of port `port` in a flattened bus of `w`-bit fields.
  function automatic int unsigned port_lsb(input int unsigned port, input int unsigned w);
    return port * w;
  endfunction

endpackage

// File: rtl/sb_track.sv
// Pending-write scoreboard: one pending bit per register plus a registered
// population count of those bits.
// Ports:
//   clk, reset           - clock, asynchronous active-low reset
//   set, setaddr         - mark setaddr pending (producer issued)
//   clr, clraddr         - clear clraddr pending (producer written back)
//   pending              - registered pending bit-vector (bit 0 always 0)
//   npend                - registered count of pending bits
module sb_track
  import mips_pkg::*;
#(
  parameter int unsigned ADDRW = DEF_ADDRW
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    set,
  input  logic [ADDRW-1:0]        setaddr,
  input  logic                    clr,
  input  logic [ADDRW-1:0]        clraddr,
  output logic [(2**ADDRW)-1:0]   pending,
  output logic [ADDRW:0]          npend
);

  localparam int unsigned DEPTH = 2 ** ADDRW;
  localparam int unsigned CNTW  = ADDRW + 1;

  logic [DEPTH-1:0] pend_q, pend_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             set_ok, clr_ok, inc, dec;

  // Next-state: set dominates clear on the same address, so a new producer
  // supersedes the one retiring; the count follows the real bit transitions.
  always_comb begin
    set_ok = set && (setaddr != ADDRW'(REG_ZERO));
    clr_ok = clr && (clraddr != ADDRW'(REG_ZERO));
    inc    = set_ok && !pend_q[setaddr];
    dec    = clr_ok && pend_q[clraddr] && !(set_ok && (setaddr == clraddr));
    pend_d = pend_q;
    if (clr_ok) pend_d[clraddr] = 1'b0;
    if (set_ok) pend_d[setaddr] = 1'b1;
    cnt_d  = cnt_q + CNTW'(inc) - CNTW'(dec);
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pending = pend_q;
  assign npend   = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with write-to-read bypass and an integrated
// pending-write scoreboard for decode-stage operand stalls.
// Ports:
//   clk, reset        - clock, asynchronous active-low reset
//   we, wa, wd        - write-back enable/address/data
//   ra, rd            - flattened read addresses / read data (NREAD ports)
//   rbusy             - per-port operand pending and not being written now
//   iss, iaddr        - issue strobe marking iaddr pending
//   ruse              - per-port operand actually consumed this cycle
//   stall             - any used port busy
//   npend             - number of pending registers
module regfile_sb
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned ADDRW  = DEF_ADDRW,
  parameter int unsigned NREAD  = 2,
  parameter int unsigned BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [ADDRW-1:0]         wa,
  input  logic [WIDTH-1:0]         wd,
  input  logic [NREAD*ADDRW-1:0]   ra,
  output logic [NREAD*WIDTH-1:0]   rd,
  output logic [NREAD-1:0]         rbusy,
  input  logic                     iss,
  input  logic [ADDRW-1:0]         iaddr,
  output logic                     stall,
  input  logic [NREAD-1:0]         ruse,
  output logic [ADDRW:0]           npend
);

  localparam int unsigned DEPTH = 2 ** ADDRW;

  logic [WIDTH-1:0] rf_q [DEPTH];
  logic [DEPTH-1:0] pending;
  logic             we_ok;

  assign we_ok = we && (wa != ADDRW'(REG_ZERO));

  // Storage; entry 0 is held at reset value and never written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < int'(DEPTH); k++) rf_q[k] <= '0;
    end else if (we_ok) begin
      rf_q[wa] <= wd;
    end
  end

  sb_track #(
    .ADDRW (ADDRW)
  ) u_sb_track (
    .clk     (clk),
    .reset   (reset),
    .set     (iss),
    .setaddr (iaddr),
    .clr     (we),
    .clraddr (wa),
    .pending (pending),
    .npend   (npend)
  );

  // Read ports: zero register, then same-cycle bypass, then storage.
  for (genvar i = 0; i < int'(NREAD); i++) begin : g_rd
    localparam int unsigned ALSB = port_lsb(i, ADDRW);
    localparam int unsigned DLSB = port_lsb(i, WIDTH);

    logic [ADDRW-1:0] ra_p;
    logic             is_zero;
    logic             hit;

    assign ra_p    = ra[ALSB +: ADDRW];
    assign is_zero = (ra_p == ADDRW'(REG_ZERO));
    assign hit     = (BYPASS != 0) && we && (wa == ra_p);

    assign rd[DLSB +: WIDTH] = is_zero ? '0 : (hit ? wd : rf_q[ra_p]);
    // A bypassed write resolves the hazard in the same cycle.
    assign rbusy[i] = pending[ra_p] && !hit && !is_zero;
  end

  assign stall = |(rbusy & ruse);

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-read-port register file with an integrated pending-write scoreboard. It replaces the fixed 32×32 three-port register file in the multicycle/pipelined MIPS datapath. It adds reset-clearable storage, same-cycle write-to-read bypass, and per-register "pending" tracking so that the decode stage can stall on operands whose producer (load, multi-cycle mul/div) has not yet written back.

## Interface
- WIDTH, 32: data width of each register.
- ADDRW, 5: address width; depth = 2**ADDRW registers.
- NREAD, 2: number of combinational read ports (1..4).
- BYPASS, 1: 1 = write data forwarded to same-cycle reads of the written address; 0 = reads return stored value only.

- clk  input  1  rising-edge clock; sole clock.
- reset  input  1  asynchronous, active-low; clears all registers and all pending bits.
- we  input  1  write-back enable.
- wa  input  ADDRW  write-back address.
- wd  input  WIDTH  write-back data.
- ra  input  NREAD*ADDRW  read addresses; port i = ra[i*ADDRW +: ADDRW].
- rd  output  NREAD*WIDTH  read data; port i = rd[i*WIDTH +: WIDTH].
- rbusy  output  NREAD  rbusy[i] = operand on port i is pending and not being written this cycle.
- iss  input  1  issue strobe: mark register `iaddr` as pending (producer in flight).
- iaddr  input  ADDRW  destination of the issued producer.
- stall  output  1  OR of rbusy over ports whose `ruse[i]` is set.
- ruse  input  NREAD  port i actually consumes its operand this cycle.
- npend  output  ADDRW+1  count of pending registers.

## Operation
- Register 0 reads 0 and is never written. A write or issue to address 0 is ignored and leaves pending[0] = 0.
- Write: on a rising clk with we=1 and wa≠0, rf[wa] ← wd and pending[wa] ← 0.
- Issue: on a rising clk with iss=1 and iaddr≠0, pending[iaddr] ← 1.
- Simultaneous iss and we to the same address: pending ends at 1, because the new producer supersedes the one retiring. Data is still written.
- Simultaneous iss and we to different addresses: both take effect.
- Read (combinational):
  - ra=0 → 0.
  - Otherwise, if BYPASS and we and wa==ra → wd.
  - Otherwise → rf[ra].
- rbusy[i] = pending[ra_i] and not (we and wa==ra_i and BYPASS).
  - With BYPASS=0 a writing register reports busy until the following cycle.
  - rbusy is always 0 for ra_i=0.
- stall = |(rbusy & ruse).
- npend is a registered population count of pending bits.
  - Updates each cycle by +1 for a set bit newly going to 1 and −1 for a bit going to 0. Net change ∈ {−1, 0, +1}.
  - Never exceeds 2**ADDRW−1.
- Issue to an already-pending register: no change to pending or npend.
- Write to a non-pending register: no change to npend.

## Timing
- Reset low (asynchronous):
  - All rf entries become 0, all pending bits become 0, npend becomes 0.
  - Hence rd=0, rbusy=0, stall=0 immediately, without waiting for clk.
- Reset release is synchronised externally. The first write or issue honoured is on the first rising clk with reset high.
- Read latency 0 cycles (combinational from ra/we/wa/wd/state).
- Write and issue latency 1 cycle. With BYPASS=1, written data is visible to same-cycle reads.
- Reset asserted mid-operation discards all in-flight pending state. No write in that cycle takes effect.
- No combinational path from rd, rbusy or stall back to we, wa or iss inside the block.

## Structure
- Shared package `mips_pkg` holds:
  - default WIDTH/ADDRW constants;
  - the REG_ZERO address constant;
  - port-slice helper functions for flattened ra/rd.
- Sub-module `sb_track`: pending bit-vector plus npend counter. Inputs: clk, reset, set/setaddr, clr/clraddr. Outputs: pending vector and npend. regfile_sb instantiates it once and adds storage, bypass and read muxing.

## Test plan
- Reset: write rf[5]=0xDEADBEEF, assert reset low between clocks → rd for ra=5 is 0 immediately, npend=0.
- Bypass: BYPASS=1, we=1, wa=7, wd=0x1234, ra0=7 → rd0=0x1234 in the same cycle. BYPASS=0 → rd0 equals the old value and 0x1234 appears the next cycle.
- Scoreboard: iss iaddr=9 → next cycle ra1=9 with ruse[1]=1 gives rbusy[1]=1, stall=1, npend=1. Then write wa=9 → rbusy[1]=0 that cycle (BYPASS=1), npend=0 after the edge.
- Collision: same-cycle iss and we to address 12 → rf[12]=wd, pending[12] stays 1, npend unchanged. Same-cycle iss 3 and we 4 (4 pending) → npend unchanged, pending moves from 4 to 3.
- Zero register: we=1, wa=0, wd=0xFFFFFFFF and iss iaddr=0 → rd(ra=0)=0, rbusy=0, npend=0.
- Saturation: issue all addresses 1..2**ADDRW−1 → npend=2**ADDRW−1. Re-issue 1 → unchanged. Write all back → npend=0.
